param_shift_register_ctl: RTL and testbench
===========================================

// Module: param_shift_register_ctl
// PURPOSE
//  Parametrised multi-mode shift register with enable/start handshake for the MIPS datapath.
//  - Executes load, logical/arithmetic shifts, rotates and serial-in shift by a variable amount.
//  - Serial by default: one bit per clock.
//  - Latches operands on start and reports busy/done, so the control unit can stall on sllv/srlv/srav.
// PARAMETERS
//  WIDTH    32               data width; power of two, >= 4
//  SHAMT_W  $clog2(WIDTH)    width of shift-amount input
// PORTS
//  CLK       in   1        single clock, rising edge
//  nRST      in   1        asynchronous, active-low reset
//  start     in   1        operation request; sampled only in IDLE
//  control   in   3        op: 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROL, 110 ROR, 111 SLI (shift left, LSB <= serialIn)
//  shamt     in   SHAMT_W  shift amount 0..WIDTH-1
//  dataIn    in   WIDTH    parallel load value (LOAD only)
//  serialIn  in   1        fill bit for SLI, sampled each shift step
//  dataOut   out  WIDTH    register contents
//  shiftOut  out  1        bit shifted/rotated out on the most recent step
//  busy      out  1        multi-cycle shift in progress
//  done      out  1        one-cycle pulse: operation complete, dataOut valid
// BEHAVIOUR
//  - Reset (nRST=0, async): dataOut=0, shiftOut=0, busy=0, done=0, cnt=0, state=IDLE.
//    Reset mid-operation aborts the operation; no done pulse.
//  - States:
//    IDLE  -> SHIFT  on start with op in {SLL..SLI} and shamt>0.
//    SHIFT -> IDLE   when cnt reaches 1 at an edge.
//  - Start edge k in IDLE latches control/shamt:
//    NOP, or shift with shamt=0: dataOut unchanged; done=1 after edge k.
//    LOAD: dataOut<=dataIn at edge k; done=1 after edge k.
//    Shift with shamt=N>0: cnt<=N, busy<=1 at edge k.
//  - In SHIFT, each edge performs one 1-bit step and decrements cnt.
//  - The step that moves cnt 1->0 also sets busy<=0 and done<=1.
//  - Shift with shamt=N: result and done after edge k+N; busy high for N cycles.
//  - Step rules (W=WIDTH):
//    SLL  {d[W-2:0],0}, shiftOut=d[W-1]
//    SRL  {0,d[W-1:1]}, shiftOut=d[0]
//    SRA  {d[W-1],d[W-1:1]}, shiftOut=d[0]
//    ROL  {d[W-2:0],d[W-1]}, shiftOut=d[W-1]
//    ROR  {d[0],d[W-1:1]}, shiftOut=d[0]
//    SLI  {d[W-2:0],serialIn}, shiftOut=d[W-1]
//  - shiftOut holds its value between operations; LOAD/NOP leave it unchanged.
//  - done is high for exactly one cycle and is cleared on the next edge.
//  - start, control, shamt, dataIn and serialIn timing:
//    start is ignored while busy; no queueing.
//    Changes to control, shamt and dataIn while busy have no effect.
//    serialIn is live and sampled on each SLI step.
//  - start may be held high continuously; a new op is accepted on the edge where state=IDLE.
//    This includes the edge that raises done, so back-to-back ops are allowed.
// CONFIGURATION
//  Macro SHIFT_BARREL_EN:
//  - Defined: every op completes at edge k; busy stays 0 and done=1 after edge k.
//    The full shamt-bit shift is applied in one step.
//    shiftOut = last bit out: d[W-shamt] for left ops, d[shamt-1] for right ops.
//    For SLI all vacated bits are filled with serialIn.
//    shamt=0 leaves dataOut and shiftOut unchanged.
//  - Undefined: serial mode as above; cnt/SHIFT state logic present.
// TESTING
//  1 nRST=0 mid-SRA with shamt=8 -> dataOut=0, busy=0, done=0 immediately.
//    No done pulse after release.
//  2 LOAD dataIn=32'hDEADBEEF -> dataOut=32'hDEADBEEF and done=1 one cycle after start.
//    busy never asserts.
//  3 LOAD 32'h80000000, then SRA shamt=4.
//    Serial: busy=1 for 4 cycles, then dataOut=32'hF8000000, done=1, shiftOut=0.
//    Barrel: same result after 1 edge.
//  4 LOAD 32'h80000001, ROL shamt=1 -> dataOut=32'h00000003, shiftOut=1.
//    Then ROR shamt=31 -> 32'h00000006.
//  5 SRL shamt=5 on 32'hFFFFFFFF; pulse start with control=001 mid-shift.
//    -> ignored; result 32'h07FFFFFF after 5 steps.
//  6 SLL shamt=0 -> done next cycle, dataOut unchanged.
//    SLI shamt=3 with serialIn=1,0,1 -> low bits 3'b101.

Source files
------------

// File: rtl/param_shift_register_ctl.sv
// rtl/param_shift_register_ctl.sv - multi-mode shift register with start/busy/done handshake
//
// Purpose:
//    Load, logical/arithmetic shift, rotate and serial-in shift of a WIDTH-bit
//    register by a variable amount. Default build shifts one bit per clock so the
//    control unit can stall on variable shifts; defining SHIFT_BARREL_EN makes
//    every op complete in a single edge.
//
// Ports:
//    CLK       in   1        clock, rising edge
//    nRST      in   1        asynchronous active-low reset
//    start     in   1        op request, sampled only in IDLE
//    control   in   3        000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA,
//                            101 ROL, 110 ROR, 111 SLI
//    shamt     in   SHAMT_W  shift amount 0..WIDTH-1
//    dataIn    in   WIDTH    parallel load value
//    serialIn  in   1        fill bit for SLI, sampled each step
//    dataOut   out  WIDTH    register contents
//    shiftOut  out  1        last bit shifted/rotated out
//    busy      out  1        serial shift in progress
//    done      out  1        one-cycle completion pulse
//
// Configuration macro: SHIFT_BARREL_EN (undefined = serial mode)

module param_shift_register_ctl #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               start,
   input  logic [2:0]         control,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [WIDTH-1:0]   dataIn,
   input  logic               serialIn,
   output logic [WIDTH-1:0]   dataOut,
   output logic               shiftOut,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;
   localparam logic [2:0] OP_ROL  = 3'b101;
   localparam logic [2:0] OP_ROR  = 3'b110;
   localparam logic [2:0] OP_SLI  = 3'b111;

   logic [WIDTH-1:0] data_q, data_d;
   logic             so_q, so_d;
   logic             done_q, done_d;

`ifdef SHIFT_BARREL_EN

   localparam logic [SHAMT_W:0] W_EXT = (SHAMT_W+1)'(WIDTH);

   // Returns {shift_out, result}. Caller guarantees n > 0 for shift ops.
   function automatic logic [WIDTH:0] barrel(input logic [2:0]         op,
                                             input logic [WIDTH-1:0]   d,
                                             input logic [SHAMT_W-1:0] n,
                                             input logic               sin);
      logic [WIDTH-1:0]   r;
      logic [WIDTH-1:0]   left_last;
      logic [WIDTH-1:0]   right_last;
      logic [WIDTH-1:0]   fill;
      logic [SHAMT_W-1:0] nm1;
      logic [SHAMT_W:0]   wmn;
      logic               so;
      nm1        = n - 1'b1;
      wmn        = W_EXT - {1'b0, n};
      // The last bit out is the MSB after shifting one position short, and
      // likewise the LSB for right-going ops.
      left_last  = d << nm1;
      right_last = d >> nm1;
      fill       = sin ? ~({WIDTH{1'b1}} << n) : '0;
      r          = d;
      so         = 1'b0;
      case (op)
         OP_SLL: begin r = d << n;                 so = left_last[WIDTH-1]; end
         OP_SRL: begin r = d >> n;                 so = right_last[0];      end
         OP_SRA: begin r = $signed(d) >>> n;       so = right_last[0];      end
         OP_ROL: begin r = (d << n) | (d >> wmn);  so = left_last[WIDTH-1]; end
         OP_ROR: begin r = (d >> n) | (d << wmn);  so = right_last[0];      end
         OP_SLI: begin r = (d << n) | fill;        so = left_last[WIDTH-1]; end
         default: begin r = d;                     so = 1'b0;               end
      endcase
      return {so, r};
   endfunction

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         data_q <= '0;
         so_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         data_q <= data_d;
         so_q   <= so_d;
         done_q <= done_d;
      end
   end

   always_comb begin
      data_d = data_q;
      so_d   = so_q;
      done_d = 1'b0;
      if (start) begin
         done_d = 1'b1;
         if (control == OP_LOAD) begin
            data_d = dataIn;
         end else if (control != OP_NOP && shamt != '0) begin
            {so_d, data_d} = barrel(control, data_q, shamt, serialIn);
         end
      end
   end

   always_comb begin
      dataOut  = data_q;
      shiftOut = so_q;
      busy     = 1'b0;
      done     = done_q;
   end

`else

   typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               busy_q, busy_d;
   logic               is_shift_req;

   // One 1-bit step; returns {shift_out, result}.
   function automatic logic [WIDTH:0] step1(input logic [2:0]       op,
                                            input logic [WIDTH-1:0] d,
                                            input logic             sin);
      case (op)
         OP_SLL:  return {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
         OP_SRL:  return {d[0], 1'b0, d[WIDTH-1:1]};
         OP_SRA:  return {d[0], d[WIDTH-1], d[WIDTH-1:1]};
         OP_ROL:  return {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
         OP_ROR:  return {d[0], d[0], d[WIDTH-1:1]};
         OP_SLI:  return {d[WIDTH-1], d[WIDTH-2:0], sin};
         default: return {1'b0, d};
      endcase
   endfunction

   // Ops 010..111 are all shifts; a zero amount completes like a NOP.
   assign is_shift_req = start && (control >= OP_SLL) && (shamt != '0);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NOP;
         data_q  <= '0;
         so_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         data_q  <= data_d;
         so_q    <= so_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (is_shift_req) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      data_d = data_q;
      so_d   = so_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (control == OP_LOAD) begin
                  data_d = dataIn;
                  done_d = 1'b1;
               end else if (is_shift_req) begin
                  op_d   = control;
                  cnt_d  = shamt;
                  busy_d = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            {so_d, data_d} = step1(op_q, data_q, serialIn);
            cnt_d          = cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      dataOut  = data_q;
      shiftOut = so_q;
      busy     = busy_q;
      done     = done_q;
   end

`endif

endmodule

// File: tb/tb_param_shift_register_ctl.sv
// tb/tb_param_shift_register_ctl.sv - bench for param_shift_register_ctl

module tb_param_shift_register_ctl;

   localparam int W = 32;

   logic          clk;
   logic          nrst;
   logic          start;
   logic [2:0]    control;
   logic [4:0]    shamt;
   logic [W-1:0]  data_in;
   logic          serial_in;
   logic [W-1:0]  data_out;
   logic          shift_out;
   logic          busy;
   logic          done;

   int n_checks;
   int n_pass;

   logic [W-1:0] m_data;
   logic         m_so;

   param_shift_register_ctl #(.WIDTH(W)) dut (
      .CLK      (clk),
      .nRST     (nrst),
      .start    (start),
      .control  (control),
      .shamt    (shamt),
      .dataIn   (data_in),
      .serialIn (serial_in),
      .dataOut  (data_out),
      .shiftOut (shift_out),
      .busy     (busy),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-operation arithmetic. sbits[0] is the first serial bit in.
   function automatic void model_op(input logic [2:0] op, input int n,
                                    input logic [W-1:0] din, input logic [W-1:0] sbits);
      logic [W-1:0] b;
      b = '0;
      for (int i = 0; i < n; i++) b = (b << 1) | W'(sbits[i]);
      if (op == 3'b001) begin
         m_data = din;
      end else if (op != 3'b000 && n != 0) begin
         case (op)
            3'b010: begin m_so = 1'((m_data >> (W - n)) & 1); m_data = m_data << n; end
            3'b011: begin m_so = 1'((m_data >> (n - 1)) & 1); m_data = m_data >> n; end
            3'b100: begin m_so = 1'((m_data >> (n - 1)) & 1); m_data = $signed(m_data) >>> n; end
            3'b101: begin m_so = 1'((m_data >> (W - n)) & 1); m_data = (m_data << n) | (m_data >> (W - n)); end
            3'b110: begin m_so = 1'((m_data >> (n - 1)) & 1); m_data = (m_data >> n) | (m_data << (W - n)); end
            default: begin m_so = 1'((m_data >> (W - n)) & 1); m_data = (m_data << n) | b; end
         endcase
      end
   endfunction

   function automatic int exp_latency(input logic [2:0] op, input int n);
`ifdef SHIFT_BARREL_EN
      return 0;
`else
      return (op >= 3'b010 && n > 0) ? n : 0;
`endif
   endfunction

   // Issues one op with a single-cycle start pulse; returns edges after the
   // accepting edge until done (-1 on timeout) and whether busy held meanwhile.
   // Operand inputs are scrambled while busy to show they are not re-sampled.
   task automatic drive_op(input logic [2:0] op, input int n, input logic [W-1:0] din,
                           input logic [W-1:0] sbits, output int lat, output bit busy_ok);
      @(posedge clk); #1;
      start = 1'b1; control = op; shamt = 5'(n); data_in = din; serial_in = sbits[0];
      @(posedge clk); #1;
      start = 1'b0; lat = 0; busy_ok = 1'b1;
      forever begin
         @(negedge clk);
         if (done === 1'b1) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (lat > W + 4) begin lat = -1; break; end
         @(posedge clk); #1;
         lat++;
         serial_in = sbits[lat[4:0]];
         control   = 3'($urandom);
         shamt     = 5'($urandom);
         data_in   = $urandom;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0; start = 1'b0; control = '0; shamt = '0; data_in = '0; serial_in = 1'b0;
      m_data = '0; m_so = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({data_out, shift_out, busy, done} !== {32'h0, 3'b000})
         $display("FAIL reset_state got %h/%b%b%b exp 0/000", data_out, shift_out, busy, done);
      else n_pass++;
      nrst = 1'b1;
   endtask

   task automatic test_load;
      int lat; bit bok;
      drive_op(3'b001, 0, 32'hDEADBEEF, '0, lat, bok);
      model_op(3'b001, 0, 32'hDEADBEEF, '0);
      n_checks++;
      if (lat !== 0 || data_out !== 32'hDEADBEEF || busy !== 1'b0)
         $display("FAIL load got lat=%0d data=%h busy=%b exp lat=0 data=deadbeef busy=0", lat, data_out, busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL done_single_cycle got %b exp 0", done);
      else n_pass++;
   endtask

   task automatic test_sra;
      int lat; bit bok;
      drive_op(3'b001, 0, 32'h80000000, '0, lat, bok);
      model_op(3'b001, 0, 32'h80000000, '0);
      drive_op(3'b100, 4, '0, '0, lat, bok);
      model_op(3'b100, 4, '0, '0);
      n_checks++;
      if (lat !== exp_latency(3'b100, 4) || (lat > 0 && !bok))
         $display("FAIL sra_timing got lat=%0d busy_ok=%0b exp lat=%0d", lat, bok, exp_latency(3'b100, 4));
      else n_pass++;
      n_checks++;
      if (data_out !== 32'hF8000000 || shift_out !== 1'b0 || busy !== 1'b0)
         $display("FAIL sra_result got %h so=%b busy=%b exp f8000000 so=0 busy=0", data_out, shift_out, busy);
      else n_pass++;
   endtask

   task automatic test_rotate;
      int lat; bit bok;
      drive_op(3'b001, 0, 32'h80000001, '0, lat, bok);
      model_op(3'b001, 0, 32'h80000001, '0);
      drive_op(3'b101, 1, '0, '0, lat, bok);
      model_op(3'b101, 1, '0, '0);
      n_checks++;
      if (data_out !== 32'h00000003 || shift_out !== 1'b1 || lat !== exp_latency(3'b101, 1))
         $display("FAIL rol1 got %h so=%b lat=%0d exp 00000003 so=1", data_out, shift_out, lat);
      else n_pass++;
      drive_op(3'b110, 31, '0, '0, lat, bok);
      model_op(3'b110, 31, '0, '0);
      n_checks++;
      if (data_out !== 32'h00000006 || lat !== exp_latency(3'b110, 31) || shift_out !== m_so)
         $display("FAIL ror31 got %h so=%b lat=%0d exp 00000006 so=%b", data_out, shift_out, lat, m_so);
      else n_pass++;
   endtask

   task automatic test_sll0_sli;
      int lat; bit bok; logic [W-1:0] sb;
      drive_op(3'b010, 0, '0, '0, lat, bok);
      n_checks++;
      if (lat !== 0 || data_out !== m_data || shift_out !== m_so)
         $display("FAIL sll0 got lat=%0d %h so=%b exp lat=0 %h so=%b", lat, data_out, shift_out, m_data, m_so);
      else n_pass++;
`ifdef SHIFT_BARREL_EN
      sb = 32'hFFFFFFFF;
`else
      sb = 32'h00000005;
`endif
      drive_op(3'b111, 3, '0, sb, lat, bok);
      model_op(3'b111, 3, '0, sb);
      n_checks++;
      if (data_out !== m_data || lat !== exp_latency(3'b111, 3) || shift_out !== m_so)
         $display("FAIL sli3 got %h lat=%0d so=%b exp %h so=%b", data_out, lat, shift_out, m_data, m_so);
      else n_pass++;
`ifndef SHIFT_BARREL_EN
      n_checks++;
      if (data_out[2:0] !== 3'b101) $display("FAIL sli3_low got %b exp 101", data_out[2:0]);
      else n_pass++;
`endif
   endtask

`ifndef SHIFT_BARREL_EN
   task automatic test_ignore_start;
      int lat; bit bok;
      drive_op(3'b001, 0, 32'hFFFFFFFF, '0, lat, bok);
      model_op(3'b001, 0, 32'hFFFFFFFF, '0);
      @(posedge clk); #1;
      start = 1'b1; control = 3'b011; shamt = 5'd5;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; control = 3'b001; data_in = 32'h0;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 2;
      while (lat < 12) begin
         @(negedge clk);
         if (done === 1'b1) break;
         @(posedge clk); #1;
         lat++;
      end
      model_op(3'b011, 5, '0, '0);
      n_checks++;
      if (lat !== 5 || data_out !== 32'h07FFFFFF)
         $display("FAIL srl_ignore_start got lat=%0d %h exp lat=5 07ffffff", lat, data_out);
      else n_pass++;
   endtask
`endif

   task automatic test_random;
      int lat; bit bok; logic [2:0] op; int n; logic [W-1:0] din; logic [W-1:0] sb;
      for (int it = 0; it < 40; it++) begin
         op  = 3'($urandom);
         n   = int'($urandom_range(0, W - 1));
         din = $urandom;
`ifdef SHIFT_BARREL_EN
         sb  = {W{1'($urandom)}};
`else
         sb  = $urandom;
`endif
         drive_op(op, n, din, sb, lat, bok);
         model_op(op, n, din, sb);
         n_checks++;
         if (lat !== exp_latency(op, n) || (lat > 0 && !bok) || busy !== 1'b0)
            $display("FAIL rand_timing op=%0d n=%0d got lat=%0d busy_ok=%0b exp lat=%0d", op, n, lat, bok, exp_latency(op, n));
         else n_pass++;
         n_checks++;
         if (data_out !== m_data || shift_out !== m_so)
            $display("FAIL rand_result op=%0d n=%0d got %h so=%b exp %h so=%b", op, n, data_out, shift_out, m_data, m_so);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back;
      int k;
      @(posedge clk); #1;
      start = 1'b1; control = 3'b001; data_in = 32'h12345678;
      @(posedge clk); #1;
      data_in = 32'hCAFEF00D;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || data_out !== 32'h12345678)
         $display("FAIL b2b_first got done=%b %h exp done=1 12345678", done, data_out);
      else n_pass++;
      @(posedge clk); #1;
      control = 3'b011; shamt = 5'd2;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || data_out !== 32'hCAFEF00D)
         $display("FAIL b2b_second got done=%b %h exp done=1 cafef00d", done, data_out);
      else n_pass++;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (k < 6) begin
         @(negedge clk);
         if (done === 1'b1) break;
         @(posedge clk); #1;
         k++;
      end
      m_data = 32'hCAFEF00D;
      model_op(3'b011, 2, '0, '0);
      n_checks++;
      if (k !== exp_latency(3'b011, 2) || data_out !== m_data)
         $display("FAIL b2b_shift got lat=%0d %h exp lat=%0d %h", k, data_out, exp_latency(3'b011, 2), m_data);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op;
      int lat; bit bok; int dones;
      drive_op(3'b001, 0, 32'h80000000, '0, lat, bok);
      @(posedge clk); #1;
      start = 1'b1; control = 3'b100; shamt = 5'd8;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 nrst = 1'b0;
      #1;
      n_checks++;
      if ({data_out, shift_out, busy, done} !== {32'h0, 3'b000})
         $display("FAIL reset_mid_op got %h/%b%b%b exp 0/000", data_out, shift_out, busy, done);
      else n_pass++;
      m_data = '0; m_so = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      dones = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || data_out !== 32'h0)
         $display("FAIL reset_no_done got %0d pulses data=%h exp 0 pulses data=0", dones, data_out);
      else n_pass++;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      test_load();
      test_sra();
      test_rotate();
      test_sll0_sli();
`ifndef SHIFT_BARREL_EN
      test_ignore_start();
`endif
      test_back_to_back();
      test_random();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
